// File: rtl/fire3_pkg.sv
// Shared constants, derived widths and FSM state type for the fire3 expand-3x3 feeder.
package fire3_pkg;

  localparam int W_IN          = 64;
  localparam int H_IN          = 64;
  localparam int CHIN          = 16;
  localparam int KERNEL_DIM    = 3;
  localparam int PAD           = 1;
  localparam int WIDTH         = 16;
  localparam int BEATS_PER_WIN = CHIN * KERNEL_DIM * KERNEL_DIM;  // 144
  localparam int ADDR_W        = $clog2(CHIN * H_IN * W_IN);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_GAP   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fire3_window_addr_gen.sv
// Window/beat counters for the expand-3x3 feeder: produces the squeeze-RAM
// read address for the current beat plus a flag marking zero-padding beats.
module fire3_window_addr_gen
  import fire3_pkg::*;
#(
  parameter int W_IN       = fire3_pkg::W_IN,
  parameter int H_IN       = fire3_pkg::H_IN,
  parameter int CHIN       = fire3_pkg::CHIN,
  parameter int KERNEL_DIM = fire3_pkg::KERNEL_DIM,
  parameter int PAD        = fire3_pkg::PAD,
  parameter int AW         = fire3_pkg::ADDR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_beat_en,    // advance ch/ky/kx by one beat
  input  logic          i_win_en,     // advance ox/oy by one window
  output logic [AW-1:0] o_addr,
  output logic          o_pad,
  output logic          o_beat_last,  // current beat is the last of the window
  output logic          o_win_last    // current window is the last of the pass
);

  localparam int OY_W = cnt_w(H_IN);
  localparam int OX_W = cnt_w(W_IN);
  localparam int CH_W = cnt_w(CHIN);
  localparam int K_W  = cnt_w(KERNEL_DIM);

  logic [OY_W-1:0] r_oy;
  logic [OX_W-1:0] r_ox;
  logic [CH_W-1:0] r_ch;
  logic [K_W-1:0]  r_ky;
  logic [K_W-1:0]  r_kx;

  int w_iy;
  int w_ix;
  int w_iy_c;
  int w_ix_c;
  int w_lin;

  // Beat counters nest ch > ky > kx; window counters nest oy > ox; all wrap to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_oy <= '0;
      r_ox <= '0;
      r_ch <= '0;
      r_ky <= '0;
      r_kx <= '0;
    end else begin
      // NOTE: non-blocking assignments so every counter sees pre-edge values and updates together.
      if (i_beat_en) begin
        if (r_kx == K_W'(KERNEL_DIM - 1)) begin
          r_kx <= '0;
          if (r_ky == K_W'(KERNEL_DIM - 1)) begin
            r_ky <= '0;
            r_ch <= (r_ch == CH_W'(CHIN - 1)) ? '0 : r_ch + CH_W'(1);
          end else begin
            r_ky <= r_ky + K_W'(1);
          end
        end else begin
          r_kx <= r_kx + K_W'(1);
        end
      end
      if (i_win_en) begin
        if (r_ox == OX_W'(W_IN - 1)) begin
          r_ox <= '0;
          r_oy <= (r_oy == OY_W'(H_IN - 1)) ? '0 : r_oy + OY_W'(1);
        end else begin
          r_ox <= r_ox + OX_W'(1);
        end
      end
    end
  end

  // Source coordinate, pad detection and clamped linear address for the current beat.
  always_comb begin
    // NOTE: every variable gets a value on every path, so no latch is inferred.
    w_iy   = int'(r_oy) + int'(r_ky) - PAD;
    w_ix   = int'(r_ox) + int'(r_kx) - PAD;
    o_pad  = (w_iy < 0) || (w_iy >= H_IN) || (w_ix < 0) || (w_ix >= W_IN);
    w_iy_c = (w_iy < 0) ? 0 : ((w_iy > H_IN - 1) ? H_IN - 1 : w_iy);
    w_ix_c = (w_ix < 0) ? 0 : ((w_ix > W_IN - 1) ? W_IN - 1 : w_ix);
    w_lin  = (int'(r_ch) * H_IN + w_iy_c) * W_IN + w_ix_c;
    o_addr = AW'(w_lin);
    o_beat_last = (r_ch == CH_W'(CHIN - 1)) && (r_ky == K_W'(KERNEL_DIM - 1)) &&
                  (r_kx == K_W'(KERNEL_DIM - 1));
    o_win_last  = (r_oy == OY_W'(H_IN - 1)) && (r_ox == OX_W'(W_IN - 1));
  end

endmodule

// File: rtl/fire3_expand_3_feeder.sv
// Streams zero-padded KxK windows of the squeeze feature map into the
// expand-3x3 MAC array: FSM, one-cycle RAM-latency pipeline and output registers.
module fire3_expand_3_feeder
  import fire3_pkg::*;
#(
  parameter int W_IN       = fire3_pkg::W_IN,
  parameter int H_IN       = fire3_pkg::H_IN,
  parameter int CHIN       = fire3_pkg::CHIN,
  parameter int KERNEL_DIM = fire3_pkg::KERNEL_DIM,
  parameter int PAD        = fire3_pkg::PAD,
  parameter int WIDTH      = fire3_pkg::WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  output logic [$clog2(CHIN*H_IN*W_IN)-1:0]    fm_addr,
  input  logic [WIDTH-1:0]                     fm_rdata,
  output logic [WIDTH-1:0]                     ifm,
  output logic                                 ifm_valid,
  output logic                                 win_last,
  output logic                                 busy,
  output logic                                 done
);

  localparam int AW = $clog2(CHIN * H_IN * W_IN);

  state_t          r_state;
  state_t          w_next_state;
  logic            w_beat_en;
  logic            w_win_en;
  logic            w_done_set;
  logic            w_pad;
  logic            w_beat_last;
  logic            w_win_last;
  logic [AW-1:0]   w_addr;

  // Stage 1: travels alongside the RAM read.
  logic            r_v1;
  logic            r_pad1;
  logic            r_last1;

  // Stage 2: registered outputs.
  logic [WIDTH-1:0] r_ifm;
  logic             r_ifm_valid;
  logic             r_win_last;
  logic             r_busy;
  logic             r_done;

  fire3_window_addr_gen #(
    .W_IN       (W_IN),
    .H_IN       (H_IN),
    .CHIN       (CHIN),
    .KERNEL_DIM (KERNEL_DIM),
    .PAD        (PAD),
    .AW         (AW)
  ) u_addr_gen (
    .clk         (clk),
    .rst_n       (rst),
    .i_beat_en   (w_beat_en),
    .i_win_en    (w_win_en),
    .o_addr      (w_addr),
    .o_pad       (w_pad),
    .o_beat_last (w_beat_last),
    .o_win_last  (w_win_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state and counter-enable decode; done fires once both pipeline stages are empty.
  always_comb begin
    w_next_state = r_state;
    w_beat_en    = 1'b0;
    w_win_en     = 1'b0;
    w_done_set   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // r_done still high means start coincides with the done pulse: ignore it.
        if (start && !r_done) w_next_state = ST_RUN;
      end
      ST_RUN: begin
        w_beat_en = 1'b1;
        if (w_beat_last) w_next_state = ST_GAP;
      end
      ST_GAP: begin
        w_win_en     = 1'b1;
        w_next_state = w_win_last ? ST_FLUSH : ST_RUN;
      end
      ST_FLUSH: begin
        if (!r_v1 && !r_ifm_valid) begin
          w_done_set   = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Pad flag and beat markers delayed by the RAM read latency, then the output stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1        <= 1'b0;
      r_pad1      <= 1'b0;
      r_last1     <= 1'b0;
      r_ifm       <= '0;
      r_ifm_valid <= 1'b0;
      r_win_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_v1        <= (r_state == ST_RUN);
      r_pad1      <= w_pad;
      r_last1     <= (r_state == ST_RUN) && w_beat_last;
      r_ifm       <= (r_v1 && !r_pad1) ? fm_rdata : '0;
      r_ifm_valid <= r_v1;
      r_win_last  <= r_last1;
      r_busy      <= (w_next_state != ST_IDLE);
      r_done      <= w_done_set;
    end
  end

  assign fm_addr   = w_addr;
  assign ifm       = r_ifm;
  assign ifm_valid = r_ifm_valid;
  assign win_last  = r_win_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_fire3_expand_3_feeder.sv
// Scoreboard bench for fire3_expand_3_feeder on a small, non-square map.
module tb_fire3_expand_3_feeder;

  localparam int W_IN     = 5;
  localparam int H_IN     = 4;
  localparam int CHIN     = 3;
  localparam int K        = 3;
  localparam int PAD      = 1;
  localparam int WIDTH    = 16;
  localparam int AW       = $clog2(CHIN * H_IN * W_IN);
  localparam int BEATS    = CHIN * K * K;
  localparam int PASS_CYC = H_IN * W_IN * (BEATS + 1);

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [AW-1:0]    fm_addr;
  logic [WIDTH-1:0] fm_rdata = '0;
  logic [WIDTH-1:0] ifm;
  logic             ifm_valid;
  logic             win_last;
  logic             busy;
  logic             done;

  logic [WIDTH-1:0] mem [64];
  beat_t            exp_q [$];
  beat_t            b;

  int cyc = 0;
  int n_vec = 0;
  int n_fail = 0;
  int start_cyc = 0;
  int last_wl_cyc = 0;
  int done_cnt = 0;
  bit lat_armed = 1'b0;
  bit done_armed = 1'b0;
  bit prev_last = 1'b0;

  fire3_expand_3_feeder #(
    .W_IN       (W_IN),
    .H_IN       (H_IN),
    .CHIN       (CHIN),
    .KERNEL_DIM (K),
    .PAD        (PAD),
    .WIDTH      (WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .fm_addr   (fm_addr),
    .fm_rdata  (fm_rdata),
    .ifm       (ifm),
    .ifm_valid (ifm_valid),
    .win_last  (win_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data for an address appears one cycle later.
  always @(posedge clk) fm_rdata <= mem[fm_addr];
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: every window in raster order, channel-major beats, zero outside the map.
  task automatic push_pass();
    beat_t e;
    for (int oy = 0; oy < H_IN; oy++)
      for (int ox = 0; ox < W_IN; ox++)
        for (int ch = 0; ch < CHIN; ch++)
          for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++) begin
              int iy = oy + ky - PAD;
              int ix = ox + kx - PAD;
              bit inr = (iy >= 0) && (iy < H_IN) && (ix >= 0) && (ix < W_IN);
              e.data = inr ? mem[(ch * H_IN + iy) * W_IN + ix] : '0;
              e.last = (ch == CHIN - 1) && (ky == K - 1) && (kx == K - 1);
              exp_q.push_back(e);
            end
  endtask

  task automatic fill_mem(input bit identity);
    for (int i = 0; i < 64; i++) mem[i] = identity ? WIDTH'(i) : WIDTH'($urandom);
  endtask

  task automatic run_start();
    push_pass();
    done_armed = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    start_cyc = cyc;
    lat_armed = 1'b1;
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  // Returns at the negedge where done is first seen high, or after the budget.
  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_fm_addr"},   64'(fm_addr),   64'd0);
    check({tag, "_ifm"},       64'(ifm),       64'd0);
    check({tag, "_ifm_valid"}, 64'(ifm_valid), 64'd0);
    check({tag, "_win_last"},  64'(win_last),  64'd0);
    check({tag, "_busy"},      64'(busy),      64'd0);
    check({tag, "_done"},      64'(done),      64'd0);
  endtask

  // Monitor: pops the scoreboard on each valid beat, checks gaps and done timing.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_last = 1'b0;
      end else begin
        if (prev_last) begin
          check("gap_ifm_valid", 64'(ifm_valid), 64'd0);
          check("gap_ifm", 64'(ifm), 64'd0);
        end
        if (ifm_valid) begin
          if (lat_armed) begin
            check("first_beat_latency", 64'(cyc - start_cyc), 64'd2);
            lat_armed = 1'b0;
          end
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 64'(ifm_valid), 64'd0);
          end else begin
            b = exp_q.pop_front();
            check("ifm", 64'(ifm), 64'(b.data));
            check("win_last", 64'(win_last), 64'(b.last));
          end
          if (win_last) last_wl_cyc = cyc;
        end else if (win_last) begin
          check("win_last_without_valid", 64'(win_last), 64'd0);
        end
        prev_last = ifm_valid && win_last;
        if (done) begin
          done_cnt++;
          check("done_expected", 64'(done), 64'(done_armed));
          check("done_after_last_beat", 64'(cyc - last_wl_cyc), 64'd2);
          check("queue_empty_at_done", 64'(exp_q.size()), 64'd0);
          check("busy_low_at_done", 64'(busy), 64'd0);
          done_armed = 1'b0;
        end
      end
    end
  end

  // Stimulus.
  initial begin
    int d_before;
    int n;
    fill_mem(1'b1);

    // Reset state.
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    @(negedge clk) rst = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);

    // Pass 1: identity RAM, plus a stray start ~50 cycles in that must be ignored.
    run_start();
    repeat (47) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("busy_mid_pass", 64'(busy), 64'd1);
    wait_done(PASS_CYC + 20);

    // Pass 2: random RAM; start raised while done is high must be ignored.
    repeat ($urandom_range(1, 10)) @(negedge clk);
    fill_mem(1'b0);
    run_start();
    wait_done(PASS_CYC + 20);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(negedge clk);
    check("start_with_done_ignored", 64'(busy), 64'd0);

    // Pass 3: random RAM, aborted by an asynchronous reset mid-pass.
    fill_mem(1'b0);
    run_start();
    n = $urandom_range(30, PASS_CYC - 40);
    repeat (n) @(posedge clk);
    #3 rst = 1'b0;
    #1 check_outputs_zero("abort");
    exp_q.delete();
    done_armed = 1'b0;
    lat_armed  = 1'b0;
    d_before   = done_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (60) @(negedge clk);
    check("no_done_after_abort", 64'(done_cnt), 64'(d_before));
    check("no_restart_after_abort", 64'(busy), 64'd0);

    // Passes 4..6: restart from window (0,0), identity then random RAM contents.
    for (int p = 0; p < 3; p++) begin
      fill_mem(p == 0);
      repeat ($urandom_range(0, 8)) @(negedge clk);
      run_start();
      wait_done(PASS_CYC + 20);
    end
    repeat (4) @(negedge clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    check("final_idle", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Watchdog.
  initial begin
    #(50000 * 10);
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fire3_expand_3_feeder.md
FIRE3_EXPAND_3_FEEDER -- requirements
Module: fire3_expand_3_feeder

Interface
REQ-001 The block SHALL have parameter W_IN, default 64, input map width.
REQ-002 The block SHALL have parameter H_IN, default 64, input map height.
REQ-003 The block SHALL have parameter CHIN, default 16, input channels.
REQ-004 The block SHALL have parameter KERNEL_DIM, default 3, window size.
REQ-005 The block SHALL have parameter PAD, default 1, zero-padding width.
REQ-006 The block SHALL have parameter WIDTH, default 16, pixel width.
REQ-007 The block SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-008 The block SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-009 The block SHALL have port start, input, 1 bit, a one-cycle pulse that begins a layer pass.
REQ-010 The block SHALL have port fm_addr, output, clog2(CHIN*H_IN*W_IN) bits, squeeze-output RAM read address.
REQ-011 The block SHALL have port fm_rdata, input, WIDTH bits, RAM read data, valid exactly one cycle after fm_addr.
REQ-012 The block SHALL have port ifm, output, WIDTH bits, the pixel stream to the expand-3x3 MAC array.
REQ-013 The block SHALL have port ifm_valid, output, 1 bit, high while ifm carries a window beat.
REQ-014 The block SHALL have port win_last, output, 1 bit, high on beat 143 of each window.
REQ-015 The block SHALL have port busy, output, 1 bit, high from the start edge until done.
REQ-016 The block SHALL have port done, output, 1 bit, a one-cycle pulse after the final window.

Function
REQ-017 The block SHALL visit windows in raster order (oy outer, ox inner), 0..H_IN-1 and 0..W_IN-1, with stride 1.
REQ-018 Within each window the beat order SHALL be ch outer, ky, then kx inner, where beat index = ch*9+ky*3+kx, matching the weight ROM address order.
REQ-019 Each window SHALL occupy 145 cycles: 144 beats followed by 1 GAP cycle with ifm_valid=0 and ifm=0, aligned to the MAC clear slot.
REQ-020 Source coordinates SHALL be computed as iy=oy+ky-PAD and ix=ox+kx-PAD.
REQ-021 When a source coordinate is out of range, the beat SHALL output ifm=0 with ifm_valid=1.
REQ-022 For out-of-range beats, fm_addr SHALL be a clamped in-range value and fm_rdata SHALL be ignored.
REQ-023 In-range beats SHALL read fm_addr=(ch*H_IN+iy)*W_IN+ix.
REQ-024 The pad flag SHALL be pipelined alongside the RAM latency.
REQ-025 The state machine SHALL have states IDLE, RUN, GAP and FLUSH.
REQ-026 IDLE SHALL move to RUN on start.
REQ-027 RUN SHALL move to GAP after beat 143.
REQ-028 GAP SHALL move to RUN for the next window, or to FLUSH after the last window (oy=H_IN-1, ox=W_IN-1).
REQ-029 FLUSH SHALL wait for the read pipeline to drain, then pulse done and return to IDLE.
REQ-030 Latency: the first ifm_valid SHALL be high 2 cycles after the clock edge that samples start.
REQ-031 The last beat of a pass SHALL precede done by exactly 2 cycles.
REQ-032 start SHALL be ignored while busy=1.
REQ-033 start arriving in the same cycle as done SHALL be ignored.
REQ-034 One full pass SHALL take 4096*145 cycles from the first beat to the end of the final GAP.
REQ-035 All counters SHALL wrap to 0 at their terminal values, with no overflow into the next field.

Reset
REQ-036 While rst=0, state SHALL be IDLE, all counters 0, and fm_addr=0, ifm=0, ifm_valid=0, win_last=0, busy=0, done=0.
REQ-037 Reset asserted mid-pass SHALL abort the pass immediately; no done SHALL be issued.
REQ-038 After reset is released, a new start SHALL be required.

Structure
REQ-039 Shared package fire3_pkg SHALL hold W_IN, H_IN, CHIN, KERNEL_DIM, PAD, WIDTH, BEATS_PER_WIN=144, the derived address width, and the state enum typedef.
REQ-040 One sub-module, fire3_window_addr_gen, SHALL hold the oy/ox/ch/ky/kx counters and produce the address and pad flag.
REQ-041 The FSM, read-latency pipeline and output registers SHALL reside in the top module.

Verification (RAM preloaded so that word a = a)
REQ-042 Start, window (0,0) -> first 9 beats 0,0,0,0,0,1,0,64,65; the beat at ch=1, ky=1, kx=1 is 4096.
REQ-043 Window (0,1) ch0 -> beats 0,0,0,0,1,2,64,65,66; a GAP cycle precedes the window with ifm_valid=0.
REQ-044 Window (63,63) ch15 -> beats 65470,65471,0,65534,65535,0,0,0,0; done is high 2 cycles after the win_last of that window.
REQ-045 Start pulse at cycle 0 -> ifm_valid rises at cycle 2; win_last rises at cycle 145; a second start at cycle 50 has no effect.
REQ-046 rst driven low at beat 70 of window 10 -> all outputs 0 asynchronously, no done; a new start restarts at window (0,0).
